// File: rtl/uart_channel.sv
// uart_channel: configurable UART datapath (5-8 data bits, 1/2 stop, TX/RX FIFOs, error flags).
// Parity generation/checking is built only when UART_CHANNEL_PARITY_EN is defined.
module uart_channel #(
    parameter int CLOCK_SCALE_BITS = 16,
    parameter int RX_FIFO_DEPTH = 32,
    parameter int TX_FIFO_DEPTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
    input  logic [1:0] dataBits,
    input  logic [1:0] parityMode,
    input  logic stopBits,
    input  logic [3:0] clear,
    input  logic [7:0] tx_data,
    input  logic tx_valid,
    output logic tx_ready,
    output logic [7:0] rx_data,
    output logic [1:0] rx_error,
    output logic rx_valid,
    input  logic rx_ready,
    output logic [$clog2(RX_FIFO_DEPTH):0] rxCount,
    output logic [$clog2(TX_FIFO_DEPTH):0] txCount,
    output logic rxOverrun,
    output logic txIdle,
    input  logic uart_rx,
    output logic uart_tx
);
`ifdef UART_CHANNEL_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int RAW = $clog2(RX_FIFO_DEPTH);
    localparam int TAW = $clog2(TX_FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t tx_state, tx_next;
    logic [7:0] tx_mem [TX_FIFO_DEPTH];
    logic [TAW-1:0] tx_wr, tx_rd;
    logic [CLOCK_SCALE_BITS-1:0] tx_cpb, tx_tmr;
    logic [1:0] tx_db, tx_pm;
    logic [2:0] tx_idx;
    logic [7:0] tx_word;
    logic tx_sb, tx_sn, tx_push, tx_pop, tx_bit_end, tx_last, tx_par_on;

    assign tx_ready = txCount != (TAW+1)'(TX_FIFO_DEPTH);
    assign tx_push = tx_valid && tx_ready && !clear[3];
    assign tx_bit_end = tx_tmr == tx_cpb;
    assign tx_last = tx_state == STOP && tx_bit_end && tx_sn == tx_sb;
    // Popping on the last stop clock chains frames with no idle gap
    assign tx_pop = enable && txCount != '0 && !clear[1] && !clear[3] && (tx_state == IDLE || tx_last);
    assign tx_par_on = PAR_EN && ^tx_pm;
    assign txIdle = tx_state == IDLE && txCount == '0;

    always_ff @(posedge clk) if (tx_push) tx_mem[tx_wr] <= tx_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_wr <= '0;
            tx_rd <= '0;
            txCount <= '0;
        end else if (clear[3]) begin
            tx_wr <= '0;
            tx_rd <= '0;
            txCount <= '0;
        end else begin
            tx_wr <= tx_wr + TAW'(tx_push);
            tx_rd <= tx_rd + TAW'(tx_pop);
            txCount <= txCount + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tx_state <= IDLE;
        else tx_state <= tx_next;

    always_comb begin
        tx_next = tx_state;
        if (clear[1]) tx_next = IDLE;
        else if (tx_pop) tx_next = START;
        else if (tx_last) tx_next = IDLE;
        else if (tx_bit_end)
            case (tx_state)
                START: tx_next = DATA;
                DATA: if (tx_idx == {1'b1, tx_db}) tx_next = tx_par_on ? PARITY : STOP;
                PARITY: tx_next = STOP;
                default: tx_next = tx_state;
            endcase
    end

    always_comb
        uart_tx = tx_state == START ? 1'b0 : tx_state == DATA ? tx_word[tx_idx] :
                  tx_state == PARITY ? (^tx_word ^ tx_pm[1]) : 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_cpb <= '0;
            tx_tmr <= '0;
            tx_db <= '0;
            tx_pm <= '0;
            tx_sb <= 1'b0;
            tx_sn <= 1'b0;
            tx_idx <= '0;
            tx_word <= '0;
        end else if (tx_pop) begin
            tx_cpb <= cyclesPerBit;
            tx_db <= dataBits;
            tx_pm <= parityMode;
            tx_sb <= stopBits;
            tx_word <= tx_mem[tx_rd] & (8'hff >> (2'd3 - dataBits));
            tx_tmr <= '0;
            tx_idx <= '0;
            tx_sn <= 1'b0;
        end else if (tx_state != IDLE) begin
            tx_tmr <= tx_bit_end ? '0 : tx_tmr + 1'b1;
            if (tx_bit_end && tx_state == DATA) tx_idx <= tx_idx + 1'b1;
            if (tx_bit_end && tx_state == STOP) tx_sn <= 1'b1;
        end

    state_t rx_state, rx_next;
    logic [9:0] rx_mem [RX_FIFO_DEPTH];
    logic [RAW-1:0] rx_wr, rx_rd;
    logic [CLOCK_SCALE_BITS-1:0] rx_cpb, rx_tmr;
    logic [1:0] rx_db, rx_pm;
    logic [2:0] rx_idx;
    logic [7:0] rx_word;
    logic s1, s2, rx_prev, rx_line, rx_hit, rx_push, rx_pop, rx_full, rx_wr_en, rx_pe, rx_par_on;

    assign rx_line = s2 | ~enable;
    assign rx_hit = rx_tmr == (rx_state == START ? rx_cpb >> 1 : rx_cpb);
    assign rx_par_on = PAR_EN && ^rx_pm;
    assign rx_push = rx_state == STOP && rx_hit && !clear[0];
    assign rx_valid = rxCount != '0;
    assign rx_pop = rx_valid && rx_ready && !clear[2];
    assign rx_full = rxCount == (RAW+1)'(RX_FIFO_DEPTH);
    assign rx_wr_en = rx_push && (!rx_full || rx_pop) && !clear[2];
    assign {rx_error, rx_data} = rx_valid ? rx_mem[rx_rd] : 10'd0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {s1, s2, rx_prev} <= 3'b111;
        else {s1, s2, rx_prev} <= {uart_rx, s1, rx_line};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rx_state <= IDLE;
        else rx_state <= rx_next;

    // A low stop bit parks the receiver in BREAK until the line recovers
    always_comb begin
        rx_next = rx_state;
        if (clear[0]) rx_next = IDLE;
        else
            case (rx_state)
                IDLE: if (rx_prev && !rx_line) rx_next = START;
                START: if (rx_hit) rx_next = rx_line ? IDLE : DATA;
                DATA: if (rx_hit && rx_idx == {1'b1, rx_db}) rx_next = rx_par_on ? PARITY : STOP;
                PARITY: if (rx_hit) rx_next = STOP;
                STOP: if (rx_hit) rx_next = rx_line ? IDLE : BREAK;
                BREAK: if (rx_line) rx_next = IDLE;
                default: rx_next = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_cpb <= '0;
            rx_tmr <= '0;
            rx_db <= '0;
            rx_pm <= '0;
            rx_idx <= '0;
            rx_word <= '0;
            rx_pe <= 1'b0;
        end else if (rx_state == IDLE) begin
            rx_cpb <= cyclesPerBit;
            rx_db <= dataBits;
            rx_pm <= parityMode;
            rx_tmr <= '0;
            rx_idx <= '0;
            rx_word <= '0;
            rx_pe <= 1'b0;
        end else begin
            rx_tmr <= rx_hit ? '0 : rx_tmr + 1'b1;
            if (rx_hit && rx_state == DATA) begin
                rx_word[rx_idx] <= rx_line;
                rx_idx <= rx_idx + 1'b1;
            end
            if (rx_hit && rx_state == PARITY) rx_pe <= rx_line != (^rx_word ^ rx_pm[1]);
        end

    always_ff @(posedge clk) if (rx_wr_en) rx_mem[rx_wr] <= {PAR_EN & rx_pe, !rx_line, rx_word};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_wr <= '0;
            rx_rd <= '0;
            rxCount <= '0;
            rxOverrun <= 1'b0;
        end else if (clear[2]) begin
            rx_wr <= '0;
            rx_rd <= '0;
            rxCount <= '0;
            rxOverrun <= 1'b0;
        end else begin
            rx_wr <= rx_wr + RAW'(rx_wr_en);
            rx_rd <= rx_rd + RAW'(rx_pop);
            rxCount <= rxCount + (RAW+1)'(rx_wr_en) - (RAW+1)'(rx_pop);
            if (rx_push && !rx_wr_en) rxOverrun <= 1'b1;
        end
endmodule
